// File: rtl/dmem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pipe
// Purpose  : Single-port word memory behind a valid/ready request/response
//            handshake. A three-state FSM (IDLE -> ACCESS -> RESP) captures
//            one request, performs the array access, then holds the response
//            until the consumer takes it.
// Options  : DMEM_PIPE_ERR_CNT_EN adds a saturating 16-bit err_cnt output
//            that counts consumed error responses.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_pipe #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              wEn,
  input  logic              rEn,
  input  logic [ADDR_W-1:0] Add,
  input  logic [DATA_W-1:0] M_valA,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] m_valM,
  output logic              dmem_err
`ifdef DMEM_PIPE_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH is representable even when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0] c_depth_ext = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   m_valm_q, m_valm_d;
  logic                dmem_err_q, dmem_err_d;
  logic                wen_q, wen_d;
  logic                ren_q, ren_d;
  logic [ADDR_W-1:0]   add_q, add_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                w_oob;
  logic                w_conflict;
  logic                w_mem_we;
  logic [c_idx_w-1:0]  w_idx;
  logic [DATA_W-1:0]   w_rdata;

  // Full-width range check on the captured address: high bits never alias.
  assign w_oob      = ({1'b0, add_q} >= c_depth_ext);
  assign w_conflict = wen_q & ren_q;
  assign w_idx      = add_q[c_idx_w-1:0];
  assign w_rdata    = mem_q[w_idx];
  // A write landing on a reset edge is dropped so the array is untouched.
  assign w_mem_we   = (state_q == ACCESS) & wen_q & ~ren_q & ~w_oob & ~rst;

  // Next-state, request capture and response formation.
  always_comb begin
    state_d    = state_q;
    m_valm_d   = m_valm_q;
    dmem_err_d = dmem_err_q;
    wen_d      = wen_q;
    ren_d      = ren_q;
    add_d      = add_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          wen_d   = wEn;
          ren_d   = rEn;
          add_d   = Add;
          wdata_d = M_valA;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (w_oob || w_conflict) begin
          m_valm_d   = '0;
          dmem_err_d = 1'b1;
        end else if (ren_q) begin
          m_valm_d   = w_rdata;
          dmem_err_d = 1'b0;
        end else begin
          // Legal write or no-op: empty, error-free response.
          m_valm_d   = '0;
          dmem_err_d = 1'b0;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  // FSM and registered outputs; reset aborts any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      m_valm_q     <= '0;
      dmem_err_q   <= 1'b0;
      wen_q        <= 1'b0;
      ren_q        <= 1'b0;
      add_q        <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      m_valm_q     <= m_valm_d;
      dmem_err_q   <= dmem_err_d;
      wen_q        <= wen_d;
      ren_q        <= ren_d;
      add_q        <= add_d;
      wdata_q      <= wdata_d;
    end
  end

  // Storage array; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem_q[w_idx] <= wdata_q;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign m_valM     = m_valm_q;
  assign dmem_err   = dmem_err_q;

`ifdef DMEM_PIPE_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Count error responses only when the consumer actually takes them.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == RESP) && resp_ready && dmem_err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Saturating error counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire
